// File: rtl/fp_cmp_pipe_if.sv
// Operand/result bus for the FP compare pipeline.
// The master side issues operations and consumes results; the slave side is the unit itself.
interface fp_cmp_pipe_if #(
  parameter int unsigned FLEN  = 32,
  parameter int unsigned TAG_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [FLEN-1:0]  a;
  logic [FLEN-1:0]  b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [FLEN-1:0]  y;
  logic             nv;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output flush, in_valid, op, a, b, in_tag, out_ready,
    input  in_ready, out_valid, y, nv, out_tag
  );

  modport slave (
    input  flush, in_valid, op, a, b, in_tag, out_ready,
    output in_ready, out_valid, y, nv, out_tag
  );
endinterface

// File: rtl/fp_cmp_pipe.sv
// Pipelined IEEE-754 FEQ/FLT/FLE/FMIN/FMAX unit with NV flag and tag passthrough.
// Stage 0 computes the result; later stages are elastic delay registers.
module fp_cmp_pipe #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MAN_W  = 23,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5
) (
  input  logic          clk,
  input  logic          rst,
  fp_cmp_pipe_if.slave  bus
);
  localparam int unsigned FLEN = 1 + EXP_W + MAN_W;
  localparam logic [2:0] OP_FEQ  = 3'd0;
  localparam logic [2:0] OP_FLT  = 3'd1;
  localparam logic [2:0] OP_FLE  = 3'd2;
  localparam logic [2:0] OP_FMIN = 3'd3;
  localparam logic [2:0] OP_FMAX = 3'd4;
  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB only.
  localparam logic [FLEN-1:0] QNAN = FLEN'({(EXP_W + 1){1'b1}}) << (MAN_W - 1);

  logic w_a_sgn, w_b_sgn, w_a_nan, w_b_nan, w_a_snan, w_b_snan;
  logic w_both_zero, w_mag_lt, w_mag_gt, w_ord_lt, w_lt, w_eq;
  logic [FLEN-1:0] w_y;
  logic            w_nv;

  assign w_a_sgn  = bus.a[FLEN-1];
  assign w_b_sgn  = bus.b[FLEN-1];
  assign w_a_nan  = (&bus.a[FLEN-2:MAN_W]) & (|bus.a[MAN_W-1:0]);
  assign w_b_nan  = (&bus.b[FLEN-2:MAN_W]) & (|bus.b[MAN_W-1:0]);
  assign w_a_snan = w_a_nan & ~bus.a[MAN_W-1];
  assign w_b_snan = w_b_nan & ~bus.b[MAN_W-1];
  assign w_both_zero = ~(|bus.a[FLEN-2:0]) & ~(|bus.b[FLEN-2:0]);
  assign w_mag_lt = bus.a[FLEN-2:0] < bus.b[FLEN-2:0];
  assign w_mag_gt = bus.a[FLEN-2:0] > bus.b[FLEN-2:0];

  // Sign-magnitude order where -0 sorts below +0; min/max rely on that.
  assign w_ord_lt = (w_a_sgn != w_b_sgn) ? w_a_sgn : (w_a_sgn ? w_mag_gt : w_mag_lt);
  assign w_lt     = ~w_both_zero & w_ord_lt;
  assign w_eq     = (bus.a == bus.b) | w_both_zero;

  always_comb begin : compute
    w_y  = '0;
    w_nv = 1'b0;
    case (bus.op)
      OP_FEQ: begin
        w_y  = FLEN'(~w_a_nan & ~w_b_nan & w_eq);
        w_nv = w_a_snan | w_b_snan;
      end
      OP_FLT: begin
        w_y  = FLEN'(~w_a_nan & ~w_b_nan & w_lt);
        w_nv = w_a_nan | w_b_nan;
      end
      OP_FLE: begin
        w_y  = FLEN'(~w_a_nan & ~w_b_nan & (w_lt | w_eq));
        w_nv = w_a_nan | w_b_nan;
      end
      OP_FMIN, OP_FMAX: begin
        if (w_a_nan & w_b_nan)  w_y = QNAN;
        else if (w_a_nan)       w_y = bus.b;
        else if (w_b_nan)       w_y = bus.a;
        else if (bus.op == OP_FMIN) w_y = w_ord_lt ? bus.a : bus.b;
        else                    w_y = w_ord_lt ? bus.b : bus.a;
        w_nv = w_a_snan | w_b_snan;
      end
      default: begin
        w_y  = '0;
        w_nv = 1'b0;
      end
    endcase
  end

  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] r_nv;
  logic [FLEN-1:0]   r_y   [STAGES];
  logic [TAG_W-1:0]  r_tag [STAGES];
  logic [STAGES-1:0] w_load;

  // Stage k may load unless it and every stage downstream are full and the output stalls.
  always_comb begin : load_chain
    logic full;
    full   = 1'b1;
    w_load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full      = full & r_v[k];
      w_load[k] = bus.out_ready | ~full;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v  <= '0;
      r_nv <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_y[k]   <= '0;
        r_tag[k] <= '0;
      end
    end else begin
      if (w_load[0]) begin
        r_v[0]   <= bus.in_valid;
        r_y[0]   <= w_y;
        r_nv[0]  <= w_nv;
        r_tag[0] <= bus.in_tag;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_v[k]   <= r_v[k-1];
          r_y[k]   <= r_y[k-1];
          r_nv[k]  <= r_nv[k-1];
          r_tag[k] <= r_tag[k-1];
        end
      end
      if (bus.flush) r_v <= '0;
    end
  end

  assign bus.in_ready  = w_load[0];
  assign bus.out_valid = r_v[STAGES-1];
  assign bus.y         = r_y[STAGES-1];
  assign bus.nv        = r_nv[STAGES-1];
  assign bus.out_tag   = r_tag[STAGES-1];
endmodule

// File: tb/tb_fp_cmp_pipe.sv
// Scoreboard bench for fp_cmp_pipe (binary32, 2 stages): directed IEEE cases,
// streaming latency, backpressure, flush, mid-op reset and random traffic.
module tb_fp_cmp_pipe;
  localparam int unsigned STAGES = 2;

  typedef struct packed {
    logic [31:0] y;
    logic        nv;
    logic [4:0]  tag;
    logic [31:0] acc;
    logic        chk_lat;
  } exp_t;

  logic clk, rst;
  logic [31:0] cyc;
  exp_t q[$];
  int   n_tests, n_fail;
  logic lat_mode, rand_rdy;
  logic [4:0] tg;

  fp_cmp_pipe_if #(.FLEN(32), .TAG_W(5)) bus ();

  fp_cmp_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(STAGES), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Monotone integer key: larger key means larger float, with -0 below +0.
  function automatic logic [31:0] key(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic na, nb, sa, sb, zz;
    logic [31:0] y;
    logic nv;
    na = is_nan(a); nb = is_nan(b);
    sa = na & ~a[22]; sb = nb & ~b[22];
    zz = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    y = 32'd0; nv = 1'b0;
    case (op)
      3'd0: begin y = 32'(!na && !nb && (a == b || zz)); nv = sa | sb; end
      3'd1: begin y = 32'(!na && !nb && !zz && key(a) < key(b)); nv = na | nb; end
      3'd2: begin y = 32'(!na && !nb && (zz || key(a) <= key(b))); nv = na | nb; end
      3'd3, 3'd4: begin
        if (na && nb) y = 32'h7FC0_0000;
        else if (na) y = b;
        else if (nb) y = a;
        else if (op == 3'd3) y = (key(a) < key(b)) ? a : b;
        else y = (key(a) < key(b)) ? b : a;
        nv = sa | sb;
      end
      default: begin y = 32'd0; nv = 1'b0; end
    endcase
    return {y, nv};
  endfunction

  // Scoreboard: compare every handshake; while stalled, the held result must match the head.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
      end else if (bus.out_ready) begin
        exp_t e;
        e = q.pop_front();
        check("y", bus.y, e.y);
        check("nv", 32'(bus.nv), 32'(e.nv));
        check("tag", 32'(bus.out_tag), 32'(e.tag));
        if (e.chk_lat) check("latency", cyc - e.acc, 32'(STAGES));
      end else begin
        check("stall_y_held", bus.y, q[0].y);
      end
    end
  end

  task automatic set_inputs(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op = op; bus.a = a; bus.b = b; bus.in_tag = tg; bus.in_valid = 1'b1;
  endtask

  task automatic send_raw(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ey, input logic env);
    logic rdy, done;
    logic [31:0] ac;
    exp_t e;
    set_inputs(op, a, b);
    done = 1'b0; rdy = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      rdy = bus.in_ready; ac = cyc;
      @(posedge clk);
      #1;
      if (rdy) begin
        e.y = ey; e.nv = env; e.tag = tg; e.acc = ac; e.chk_lat = lat_mode;
        q.push_back(e);
        done = 1'b1;
        tg = tg + 5'd1;
      end
      if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end
    if (!done) check("accept_timeout", 32'(rdy), 32'd1);
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] m;
    m = model(op, a, b);
    send_raw(op, a, b, m[32:1], m[0]);
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
    @(posedge clk); #1;
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic count_valid(input int cycles, output int cnt);
    cnt = 0;
    for (int t = 0; t < cycles; t++) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] tbl [13];
    int i;
    tbl = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000,
            32'hC000_0000, 32'h7FC0_0000, 32'h7F80_0001, 32'h7F80_0000, 32'hFF80_0000,
            32'hFFC0_0000, 32'h0000_0001, 32'h7F7F_FFFF};
    i = int'($urandom_range(0, 16));
    return (i < 13) ? tbl[i] : $urandom;
  endfunction

  initial begin
    int cnt, n_acc;
    logic rdy;
    logic [31:0] ac, ra, rb;
    logic [2:0] rop;
    logic [32:0] m;
    exp_t e;
    n_tests = 0; n_fail = 0; cyc = 32'd0; tg = 5'd0;
    lat_mode = 1'b0; rand_rdy = 1'b0;
    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0;
    bus.in_tag = 5'd0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_y", bus.y, 32'd0);
    check("rst_nv", 32'(bus.nv), 32'd0);
    check("rst_out_tag", 32'(bus.out_tag), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed IEEE cases with hand-derived expectations.
    send_raw(3'd0, 32'h0000_0000, 32'h8000_0000, 32'd1, 1'b0);
    send_raw(3'd0, 32'h7FC0_0000, 32'h3F80_0000, 32'd0, 1'b0);
    send_raw(3'd0, 32'h7F80_0001, 32'h3F80_0000, 32'd0, 1'b1);
    send_raw(3'd1, 32'h7FC0_0000, 32'h0000_0000, 32'd0, 1'b1);
    send_raw(3'd1, 32'hBF80_0000, 32'h3F80_0000, 32'd1, 1'b0);
    send_raw(3'd2, 32'h4000_0000, 32'h4000_0000, 32'd1, 1'b0);
    send_raw(3'd1, 32'hC000_0000, 32'hBF80_0000, 32'd1, 1'b0);
    send_raw(3'd3, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0);
    send_raw(3'd4, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0);
    send_raw(3'd4, 32'h7FC0_0000, 32'h4000_0000, 32'h4000_0000, 1'b0);
    send_raw(3'd3, 32'h7F80_0001, 32'h7FC0_0000, 32'h7FC0_0000, 1'b1);
    send_raw(3'd1, 32'h0000_0000, 32'h8000_0000, 32'd0, 1'b0);
    send_raw(3'd2, 32'h8000_0000, 32'h0000_0000, 32'd1, 1'b0);
    send_raw(3'd1, 32'h3F80_0000, 32'h3F80_0000, 32'd0, 1'b0);
    send_raw(3'd4, 32'hBF80_0000, 32'hC000_0000, 32'hBF80_0000, 1'b0);
    send_raw(3'd5, 32'h3F80_0000, 32'h3F80_0000, 32'd0, 1'b0);
    send_raw(3'd7, 32'h7F80_0001, 32'h7F80_0001, 32'd0, 1'b0);
    drain();

    // Back-to-back stream, tags 0..7, exact latency.
    tg = 5'd0; lat_mode = 1'b1;
    for (int i = 0; i < 8; i++) send(3'(i % 5), pick(), pick());
    drain();
    lat_mode = 1'b0;

    // Backpressure: only STAGES accepts fit, then in_ready drops while out_ready is low.
    bus.out_ready = 1'b0; n_acc = 0;
    m = model(3'd3, 32'h3F80_0000, 32'hBF80_0000);
    set_inputs(3'd3, 32'h3F80_0000, 32'hBF80_0000);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      rdy = bus.in_ready; ac = cyc;
      @(posedge clk); #1;
      if (rdy) begin
        e.y = m[32:1]; e.nv = m[0]; e.tag = tg; e.acc = ac; e.chk_lat = 1'b0;
        q.push_back(e);
        n_acc++; tg = tg + 5'd1;
        m = model(3'd4, 32'h4000_0000, 32'(n_acc) << 23);
        set_inputs(3'd4, 32'h4000_0000, 32'(n_acc) << 23);
      end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("stall_accepts", 32'(n_acc), 32'(STAGES));
    drain();

    // Flush with two in flight plus a same-cycle input.
    bus.out_ready = 1'b0;
    send(3'd1, 32'hBF80_0000, 32'h3F80_0000);
    send(3'd3, 32'h4000_0000, 32'h3F80_0000);
    bus.flush = 1'b1;
    set_inputs(3'd4, 32'h4000_0000, 32'h3F80_0000);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    q.delete();
    count_valid(6, cnt);
    check("flush_no_output", 32'(cnt), 32'd0);
    @(posedge clk); #1;
    send_raw(3'd2, 32'hC000_0000, 32'hBF80_0000, 32'd1, 1'b0);
    drain();

    // Asynchronous reset with ops in flight.
    send(3'd4, 32'h3F80_0000, 32'h4000_0000);
    send(3'd0, 32'h3F80_0000, 32'h3F80_0000);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    #2;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_valid(5, cnt);
    check("rst_no_output", 32'(cnt), 32'd0);
    @(posedge clk); #1;

    // Random traffic with random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = pick(); rb = ($urandom_range(0, 3) == 0) ? ra : pick();
      send(rop, ra, rb);
    end
    rand_rdy = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end
endmodule
